// File: rtl/alu_core.sv
// alu_core: registered ALU with a split-operand wait timer and a 3-cycle multiply pipeline.
// Defining ALU_RES_VALID_EN adds a res_valid pulse output.
module alu_core #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CMD_WIDTH    = 4,
  parameter int unsigned WAIT_CYCLES  = 16,
  parameter int unsigned RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [DATA_WIDTH-1:0]   opa,
  input  logic [DATA_WIDTH-1:0]   opb,
  input  logic                    mode,
  input  logic [1:0]              inp_valid,
  input  logic [CMD_WIDTH-1:0]    cmd,
  input  logic                    cin,
  output logic [RESULT_WIDTH-1:0] res,
  output logic                    cout,
  output logic                    oflow,
  output logic                    g,
  output logic                    l,
  output logic                    e,
  output logic                    err
`ifdef ALU_RES_VALID_EN
  ,
  output logic                    res_valid
`endif
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned W1   = DATA_WIDTH + 1;
  localparam int unsigned SHW  = $clog2(DATA_WIDTH);
  localparam int unsigned CNTW = $clog2(WAIT_CYCLES + 1);

  localparam logic [CMD_WIDTH-1:0] ArAdd    = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] ArSub    = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] ArAddCin = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] ArSubCin = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] ArIncA   = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] ArDecA   = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] ArIncB   = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] ArDecB   = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] ArCmp    = CMD_WIDTH'(8);
  localparam logic [CMD_WIDTH-1:0] ArAddMul = CMD_WIDTH'(9);
  localparam logic [CMD_WIDTH-1:0] ArShMul  = CMD_WIDTH'(10);

  localparam logic [CMD_WIDTH-1:0] LgAnd   = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] LgNand  = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] LgOr    = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] LgNor   = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] LgXor   = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] LgXnor  = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] LgNotA  = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] LgNotB  = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] LgShr1A = CMD_WIDTH'(8);
  localparam logic [CMD_WIDTH-1:0] LgShl1A = CMD_WIDTH'(9);
  localparam logic [CMD_WIDTH-1:0] LgShr1B = CMD_WIDTH'(10);
  localparam logic [CMD_WIDTH-1:0] LgShl1B = CMD_WIDTH'(11);
  localparam logic [CMD_WIDTH-1:0] LgRolAB = CMD_WIDTH'(12);
  localparam logic [CMD_WIDTH-1:0] LgRorAB = CMD_WIDTH'(13);

  typedef enum logic [1:0] {StIdle, StWait, StMul1, StMul2} state_e;

  typedef struct packed {
    logic [RESULT_WIDTH-1:0] res;
    logic                    cout;
    logic                    oflow;
    logic                    g;
    logic                    l;
    logic                    e;
    logic                    err;
  } out_t;

  function automatic logic f_a_only(logic m, logic [CMD_WIDTH-1:0] c);
    return m ? (c == ArIncA || c == ArDecA) : (c == LgNotA || c == LgShr1A || c == LgShl1A);
  endfunction

  function automatic logic f_b_only(logic m, logic [CMD_WIDTH-1:0] c);
    return m ? (c == ArIncB || c == ArDecB) : (c == LgNotB || c == LgShr1B || c == LgShl1B);
  endfunction

  function automatic logic f_is_mul(logic m, logic [CMD_WIDTH-1:0] c);
    return m && (c == ArAddMul || c == ArShMul);
  endfunction

  function automatic logic f_cmd_ok(logic m, logic [CMD_WIDTH-1:0] c);
    return m ? (c <= ArShMul) : (c <= LgRorAB);
  endfunction

  state_e                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]            lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [CMD_WIDTH-1:0]    lat_cmd_q, lat_cmd_d;
  logic                    lat_mode_q, lat_mode_d, lat_has_a_q, lat_has_a_d;
  logic [W-1:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                    mul_sh_q, mul_sh_d;
  logic [RESULT_WIDTH-1:0] prod_q, prod_d, ma, mb;
  out_t                    out_q, out_d, alu;
  logic                    upd;

  logic [W-1:0]            x_a, x_b, lo;
  logic [CMD_WIDTH-1:0]    x_cmd;
  logic                    x_mode, do_add, do_sub;
  logic [W:0]              sum;
  logic [2*W-1:0]          rot;

  // While waiting, the latched operand/command replace the live ones.
  always_comb begin
    if (state_q == StWait) begin
      x_a    = lat_has_a_q ? lat_a_q : opa;
      x_b    = lat_has_a_q ? opb : lat_b_q;
      x_cmd  = lat_cmd_q;
      x_mode = lat_mode_q;
    end else begin
      x_a    = opa;
      x_b    = opb;
      x_cmd  = cmd;
      x_mode = mode;
    end
  end

  always_comb begin
    alu    = '0;
    lo     = '0;
    sum    = '0;
    rot    = '0;
    do_add = 1'b0;
    do_sub = 1'b0;
    if (x_mode) begin
      case (x_cmd)
        ArAdd:    begin sum = W1'(x_a) + W1'(x_b);              do_add = 1'b1; end
        ArAddCin: begin sum = W1'(x_a) + W1'(x_b) + W1'(cin);   do_add = 1'b1; end
        ArIncA:   begin sum = W1'(x_a) + W1'(1);                do_add = 1'b1; end
        ArIncB:   begin sum = W1'(x_b) + W1'(1);                do_add = 1'b1; end
        ArSub:    begin sum = W1'(x_a) - W1'(x_b);              do_sub = 1'b1; end
        ArSubCin: begin sum = W1'(x_a) - W1'(x_b) - W1'(cin);   do_sub = 1'b1; end
        ArDecA:   begin sum = W1'(x_a) - W1'(1);                do_sub = 1'b1; end
        ArDecB:   begin sum = W1'(x_b) - W1'(1);                do_sub = 1'b1; end
        ArCmp: begin
          alu.g = x_a > x_b;
          alu.l = x_a < x_b;
          alu.e = x_a == x_b;
        end
        ArAddMul, ArShMul: ;
        default: alu.err = 1'b1;
      endcase
      if (do_add || do_sub) lo = sum[W-1:0];
      alu.cout  = do_add & sum[W];
      alu.oflow = do_sub & sum[W];  // wrapped MSB is the borrow
    end else begin
      case (x_cmd)
        LgAnd:   lo = x_a & x_b;
        LgNand:  lo = ~(x_a & x_b);
        LgOr:    lo = x_a | x_b;
        LgNor:   lo = ~(x_a | x_b);
        LgXor:   lo = x_a ^ x_b;
        LgXnor:  lo = ~(x_a ^ x_b);
        LgNotA:  lo = ~x_a;
        LgNotB:  lo = ~x_b;
        LgShr1A: lo = x_a >> 1;
        LgShl1A: lo = x_a << 1;
        LgShr1B: lo = x_b >> 1;
        LgShl1B: lo = x_b << 1;
        LgRolAB: begin
          rot     = {x_a, x_a} << x_b[SHW-1:0];
          lo      = rot[2*W-1:W];
          alu.err = |x_b[W-1:SHW];
        end
        LgRorAB: begin
          rot     = {x_a, x_a} >> x_b[SHW-1:0];
          lo      = rot[W-1:0];
          alu.err = |x_b[W-1:SHW];
        end
        default: alu.err = 1'b1;
      endcase
    end
    alu.res = RESULT_WIDTH'(lo);
  end

  assign ma = RESULT_WIDTH'(mul_a_q);
  assign mb = RESULT_WIDTH'(mul_b_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_a_d     = lat_a_q;
    lat_b_d     = lat_b_q;
    lat_cmd_d   = lat_cmd_q;
    lat_mode_d  = lat_mode_q;
    lat_has_a_d = lat_has_a_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_sh_d    = mul_sh_q;
    prod_d      = prod_q;
    out_d       = out_q;
    upd         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inp_valid != 2'b00) begin
          if (!f_cmd_ok(mode, cmd)) begin
            upd       = 1'b1;
            out_d     = '0;
            out_d.err = 1'b1;
          end else if (f_a_only(mode, cmd) ? inp_valid[0] :
                       f_b_only(mode, cmd) ? inp_valid[1] : (&inp_valid)) begin
            if (f_is_mul(mode, cmd)) begin
              mul_a_d  = x_a;
              mul_b_d  = x_b;
              mul_sh_d = (cmd == ArShMul);
              state_d  = StMul1;
            end else begin
              upd   = 1'b1;
              out_d = alu;
            end
          end else if (!f_a_only(mode, cmd) && !f_b_only(mode, cmd)) begin
            lat_a_d     = opa;
            lat_b_d     = opb;
            lat_cmd_d   = cmd;
            lat_mode_d  = mode;
            lat_has_a_d = inp_valid[0];
            cnt_d       = '0;
            state_d     = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNTW'(1);
        // Arrival takes priority over a timeout in the same cycle.
        if (lat_has_a_q ? inp_valid[1] : inp_valid[0]) begin
          state_d = StIdle;
          if (cmd != lat_cmd_q || mode != lat_mode_q) begin
            upd       = 1'b1;
            out_d     = '0;
            out_d.err = 1'b1;
          end else if (f_is_mul(lat_mode_q, lat_cmd_q)) begin
            mul_a_d  = x_a;
            mul_b_d  = x_b;
            mul_sh_d = (lat_cmd_q == ArShMul);
            state_d  = StMul1;
          end else begin
            upd   = 1'b1;
            out_d = alu;
          end
        end else if (cnt_d == CNTW'(WAIT_CYCLES)) begin
          upd       = 1'b1;
          out_d     = '0;
          out_d.err = 1'b1;
          state_d   = StIdle;
        end
      end
      StMul1: begin
        prod_d  = mul_sh_q ? (ma << 1) * mb : (ma + RESULT_WIDTH'(1)) * (mb + RESULT_WIDTH'(1));
        state_d = StMul2;
      end
      StMul2: begin
        upd       = 1'b1;
        out_d     = '0;
        out_d.res = prod_q;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lat_a_q     <= '0;
      lat_b_q     <= '0;
      lat_cmd_q   <= '0;
      lat_mode_q  <= 1'b0;
      lat_has_a_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_sh_q    <= 1'b0;
      prod_q      <= '0;
      out_q       <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
      lat_cmd_q   <= lat_cmd_d;
      lat_mode_q  <= lat_mode_d;
      lat_has_a_q <= lat_has_a_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_sh_q    <= mul_sh_d;
      prod_q      <= prod_d;
      out_q       <= out_d;
    end
  end

`ifdef ALU_RES_VALID_EN
  logic res_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
    end else if (ce) begin
      res_valid_q <= upd;
    end
  end
  assign res_valid = res_valid_q;
`else
  logic unused_upd;
  assign unused_upd = upd;
`endif

  assign res   = out_q.res;
  assign cout  = out_q.cout;
  assign oflow = out_q.oflow;
  assign g     = out_q.g;
  assign l     = out_q.l;
  assign e     = out_q.e;
  assign err   = out_q.err;

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: vector table, hand-written multi-cycle sequences and
// randomized operations checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst, ce, mode, cin;
  logic [7:0]  opa, opb;
  logic [1:0]  inp_valid;
  logic [3:0]  cmd;
  logic [15:0] res;
  logic        cout, oflow, g, l, e, err;
`ifdef ALU_RES_VALID_EN
  logic        res_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_core #(
    .DATA_WIDTH (8),
    .CMD_WIDTH  (4),
    .WAIT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .opa      (opa),
    .opb      (opb),
    .mode     (mode),
    .inp_valid(inp_valid),
    .cmd      (cmd),
    .cin      (cin),
    .res      (res),
    .cout     (cout),
    .oflow    (oflow),
    .g        (g),
    .l        (l),
    .e        (e),
    .err      (err)
`ifdef ALU_RES_VALID_EN
    ,
    .res_valid(res_valid)
`endif
  );

  // fl = {cout, oflow, g, l, e, err}
  typedef struct {
    logic [15:0] res;
    logic [5:0]  fl;
  } exp_t;

  typedef struct {
    string       name;
    logic        m;
    logic [3:0]  c;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [15:0] res;
    logic [5:0]  fl;
  } vec_t;

  function automatic bit a_only(logic m, logic [3:0] c);
    return m ? (c == 4 || c == 5) : (c == 6 || c == 8 || c == 9);
  endfunction

  function automatic bit b_only(logic m, logic [3:0] c);
    return m ? (c == 6 || c == 7) : (c == 7 || c == 10 || c == 11);
  endfunction

  function automatic bit is_mul(logic m, logic [3:0] c);
    return m && (c == 9 || c == 10);
  endfunction

  function automatic exp_t model(input bit m, input int c, input int a, input int b, input int ci);
    exp_t x;
    int s;
    int n;
    x.res = '0;
    x.fl  = '0;
    s = 0;
    n = b % 8;
    if (m) begin
      case (c)
        0: s = a + b;
        2: s = a + b + ci;
        4: s = a + 1;
        6: s = b + 1;
        1: s = a - b;
        3: s = a - b - ci;
        5: s = a - 1;
        7: s = b - 1;
        default: ;
      endcase
      case (c)
        0, 2, 4, 6: begin x.res = 16'(s % 256); x.fl[5] = (s > 255); end
        1, 3, 5, 7: begin x.res = 16'((s + 256) % 256); x.fl[4] = (s < 0); end
        8: begin x.fl[3] = (a > b); x.fl[2] = (a < b); x.fl[1] = (a == b); end
        9: x.res = 16'(((a + 1) * (b + 1)) % 65536);
        10: x.res = 16'((2 * a * b) % 65536);
        default: x.fl[0] = 1'b1;
      endcase
    end else begin
      case (c)
        0: x.res = 16'(a & b);
        1: x.res = 16'(255 - (a & b));
        2: x.res = 16'(a | b);
        3: x.res = 16'(255 - (a | b));
        4: x.res = 16'(a ^ b);
        5: x.res = 16'(255 - (a ^ b));
        6: x.res = 16'(255 - a);
        7: x.res = 16'(255 - b);
        8: x.res = 16'(a / 2);
        9: x.res = 16'((a * 2) % 256);
        10: x.res = 16'(b / 2);
        11: x.res = 16'((b * 2) % 256);
        12: begin x.res = 16'(((a << n) | (a >> (8 - n))) % 256); x.fl[0] = (b > 7); end
        13: begin x.res = 16'(((a >> n) | (a << (8 - n))) % 256); x.fl[0] = (b > 7); end
        default: x.fl[0] = 1'b1;
      endcase
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [15:0] er, input logic [5:0] ef);
    checks++;
    if (res !== er || {cout, oflow, g, l, e, err} !== ef) begin
      errors++;
      $display("FAIL %s: got res=%h flags=%b, want res=%h flags=%b",
               name, res, {cout, oflow, g, l, e, err}, er, ef);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, want);
    end
  endtask

  // Drives one operation at a negedge and returns at the negedge after its result edge.
  task automatic drive_op(input logic m, input logic [3:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic ci);
    mode = m;
    cmd  = c;
    opa  = a;
    opb  = b;
    cin  = ci;
    if (a_only(m, c)) inp_valid = 2'b01;
    else if (b_only(m, c)) inp_valid = 2'b10;
    else inp_valid = 2'b11;
    @(negedge clk);
    if (is_mul(m, c)) begin
      repeat (2) begin
        opa       = 8'($urandom);
        opb       = 8'($urandom);
        cmd       = 4'($urandom);
        mode      = 1'($urandom);
        inp_valid = 2'($urandom);
        cin       = 1'($urandom);
        @(negedge clk);
      end
    end
  endtask

  vec_t tbl[$];
  exp_t x;

  initial begin
    rst       = 1'b1;
    ce        = 1'b1;
    opa       = 8'($urandom);
    opb       = 8'($urandom);
    mode      = 1'($urandom);
    cmd       = 4'($urandom);
    cin       = 1'($urandom);
    inp_valid = 2'b11;
    @(negedge clk);
    ce  = 1'b0;
    opa = 8'($urandom);
    @(negedge clk);
    check("reset", 16'h0000, 6'b000000);
    rst       = 1'b0;
    ce        = 1'b1;
    inp_valid = 2'b00;

    tbl.push_back('{"add_ff_01",   1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 16'h0000, 6'b100000});
    tbl.push_back('{"cmp_lt",      1'b1, 4'd8,  8'd5,  8'd9,  1'b0, 16'h0000, 6'b000100});
    tbl.push_back('{"cmp_eq",      1'b1, 4'd8,  8'd7,  8'd7,  1'b0, 16'h0000, 6'b000010});
    tbl.push_back('{"cmp_gt",      1'b1, 4'd8,  8'd9,  8'd5,  1'b0, 16'h0000, 6'b001000});
    tbl.push_back('{"sub_borrow",  1'b1, 4'd1,  8'd3,  8'd5,  1'b0, 16'h00FE, 6'b010000});
    tbl.push_back('{"sub_cin",     1'b1, 4'd3,  8'd10, 8'd3,  1'b1, 16'h0006, 6'b000000});
    tbl.push_back('{"add_cin",     1'b1, 4'd2,  8'h80, 8'h7F, 1'b1, 16'h0000, 6'b100000});
    tbl.push_back('{"inc_a",       1'b1, 4'd4,  8'h41, 8'h00, 1'b0, 16'h0042, 6'b000000});
    tbl.push_back('{"dec_a_zero",  1'b1, 4'd5,  8'h00, 8'h00, 1'b0, 16'h00FF, 6'b010000});
    tbl.push_back('{"inc_b_ff",    1'b1, 4'd6,  8'h00, 8'hFF, 1'b0, 16'h0000, 6'b100000});
    tbl.push_back('{"dec_b",       1'b1, 4'd7,  8'h00, 8'h10, 1'b0, 16'h000F, 6'b000000});
    tbl.push_back('{"bad_arith",   1'b1, 4'd11, 8'h12, 8'h34, 1'b0, 16'h0000, 6'b000001});
    tbl.push_back('{"err_clears",  1'b1, 4'd0,  8'h12, 8'h34, 1'b0, 16'h0046, 6'b000000});
    tbl.push_back('{"and",         1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 16'h0030, 6'b000000});
    tbl.push_back('{"nand",        1'b0, 4'd1,  8'hF0, 8'h3C, 1'b0, 16'h00CF, 6'b000000});
    tbl.push_back('{"or",          1'b0, 4'd2,  8'hF0, 8'h0F, 1'b0, 16'h00FF, 6'b000000});
    tbl.push_back('{"nor",         1'b0, 4'd3,  8'hF0, 8'h0F, 1'b0, 16'h0000, 6'b000000});
    tbl.push_back('{"xor",         1'b0, 4'd4,  8'hA5, 8'h0F, 1'b0, 16'h00AA, 6'b000000});
    tbl.push_back('{"xnor",        1'b0, 4'd5,  8'hA5, 8'h5A, 1'b0, 16'h0000, 6'b000000});
    tbl.push_back('{"not_a",       1'b0, 4'd6,  8'h0F, 8'h00, 1'b0, 16'h00F0, 6'b000000});
    tbl.push_back('{"not_b",       1'b0, 4'd7,  8'h00, 8'h33, 1'b0, 16'h00CC, 6'b000000});
    tbl.push_back('{"shr1_a",      1'b0, 4'd8,  8'h81, 8'h00, 1'b0, 16'h0040, 6'b000000});
    tbl.push_back('{"shl1_a",      1'b0, 4'd9,  8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000});
    tbl.push_back('{"shr1_b",      1'b0, 4'd10, 8'h00, 8'h81, 1'b0, 16'h0040, 6'b000000});
    tbl.push_back('{"shl1_b",      1'b0, 4'd11, 8'h00, 8'hC3, 1'b0, 16'h0086, 6'b000000});
    tbl.push_back('{"rol_1",       1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 16'h0003, 6'b000000});
    tbl.push_back('{"rol_hi_bits", 1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 16'h0003, 6'b000001});
    tbl.push_back('{"ror_1",       1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 16'h00C0, 6'b000000});
    tbl.push_back('{"ror_3",       1'b0, 4'd13, 8'h12, 8'h03, 1'b0, 16'h0042, 6'b000000});
    tbl.push_back('{"bad_logic",   1'b0, 4'd14, 8'h12, 8'h03, 1'b0, 16'h0000, 6'b000001});
    tbl.push_back('{"add_mul",     1'b1, 4'd9,  8'd3,  8'd4,  1'b0, 16'd20,   6'b000000});
    tbl.push_back('{"sh_mul",      1'b1, 4'd10, 8'd5,  8'd7,  1'b0, 16'd70,   6'b000000});
    tbl.push_back('{"add_mul_wrap",1'b1, 4'd9,  8'hFF, 8'hFF, 1'b0, 16'h0000, 6'b000000});
    tbl.push_back('{"sh_mul_ff",   1'b1, 4'd10, 8'hFF, 8'hFF, 1'b0, 16'hFC02, 6'b000000});

    foreach (tbl[i]) begin
      drive_op(tbl[i].m, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].ci);
      check(tbl[i].name, tbl[i].res, tbl[i].fl);
      inp_valid = 2'b00;
    end

    // Split operands: A first, B five cycles later.
    drive_op(1'b1, 4'd0, 8'd1, 8'd2, 1'b0);
    check("pre_split", 16'd3, 6'b000000);
    opa = 8'd10; opb = 8'd99; inp_valid = 2'b01;
    @(negedge clk);
    inp_valid = 2'b00;
    check("split_hold", 16'd3, 6'b000000);
    repeat (4) @(negedge clk);
    opa = 8'd200; opb = 8'd7; inp_valid = 2'b10;
    @(negedge clk);
    check("split_result", 16'd17, 6'b000000);
    inp_valid = 2'b00;

    // Timeout with B never arriving.
    opa = 8'd10; inp_valid = 2'b01;
    @(negedge clk);
    inp_valid = 2'b00;
    repeat (15) @(negedge clk);
    check("timeout_not_yet", 16'd17, 6'b000000);
    @(negedge clk);
    check("timeout", 16'd0, 6'b000001);

    // Arrival in the timeout cycle wins.
    opa = 8'd20; inp_valid = 2'b01;
    @(negedge clk);
    inp_valid = 2'b00;
    repeat (15) @(negedge clk);
    opb = 8'd5; inp_valid = 2'b10;
    @(negedge clk);
    check("arrive_at_timeout", 16'd25, 6'b000000);
    inp_valid = 2'b00;

    // B-first multiply, inputs during the pipeline are ignored.
    cmd = 4'd9; opb = 8'd4; inp_valid = 2'b10;
    @(negedge clk);
    inp_valid = 2'b00;
    repeat (2) @(negedge clk);
    opa = 8'd3; inp_valid = 2'b01;
    @(negedge clk);
    opa = 8'hEE; opb = 8'hDD; inp_valid = 2'b11; cmd = 4'd0;
    @(negedge clk);
    check("mul_split_wait", 16'd25, 6'b000000);
    @(negedge clk);
    check("mul_split", 16'd20, 6'b000000);
    inp_valid = 2'b00;

    // Second operand with a different command.
    mode = 1'b1; cmd = 4'd0; opa = 8'd1; inp_valid = 2'b01;
    @(negedge clk);
    inp_valid = 2'b00;
    repeat (2) @(negedge clk);
    cmd = 4'd1; opb = 8'd1; inp_valid = 2'b10;
    @(negedge clk);
    check_bit("mismatch_err", err, 1'b1);
    inp_valid = 2'b00;
    drive_op(1'b1, 4'd0, 8'd2, 8'd2, 1'b0);
    check("after_mismatch", 16'd4, 6'b000000);
    inp_valid = 2'b00;

    // Clock enable freeze.
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode = 1'b1; cmd = 4'd0; opa = 8'($urandom); opb = 8'($urandom); inp_valid = 2'b11;
      @(negedge clk);
      check($sformatf("ce_freeze_%0d", i), 16'd4, 6'b000000);
    end
    ce = 1'b1;
    inp_valid = 2'b00;
    drive_op(1'b1, 4'd0, 8'd5, 8'd6, 1'b0);
    check("ce_resume", 16'd11, 6'b000000);
    inp_valid = 2'b00;

    // Wait counter frozen while ce=0.
    mode = 1'b1; cmd = 4'd0; opa = 8'd30; inp_valid = 2'b01;
    @(negedge clk);
    ce = 1'b0;
    repeat (20) begin
      opa = 8'($urandom); opb = 8'($urandom); inp_valid = 2'($urandom);
      @(negedge clk);
    end
    ce = 1'b1;
    inp_valid = 2'b00;
    repeat (14) @(negedge clk);
    opb = 8'd2; inp_valid = 2'b10;
    @(negedge clk);
    check("ce_wait_freeze", 16'd32, 6'b000000);
    inp_valid = 2'b00;

    // Reset aborts a multiply in flight.
    mode = 1'b1; cmd = 4'd9; opa = 8'd3; opb = 8'd4; inp_valid = 2'b11;
    @(negedge clk);
    inp_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mul", 16'd0, 6'b000000);
    repeat (3) @(negedge clk);
    check("rst_mul_no_late", 16'd0, 6'b000000);

    // Reset aborts a pending split operation.
    cmd = 4'd0; opa = 8'd9; inp_valid = 2'b01;
    @(negedge clk);
    inp_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; opb = 8'd1; inp_valid = 2'b10;
    @(negedge clk);
    check("rst_wait_abort", 16'd0, 6'b000000);
    opa = 8'd4; inp_valid = 2'b01;
    @(negedge clk);
    check("rst_wait_restart", 16'd5, 6'b000000);
    inp_valid = 2'b00;

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic       rm, rci;
      logic [3:0] rc;
      logic [7:0] ra, rb;
      rm  = 1'($urandom);
      rc  = 4'($urandom);
      ra  = 8'($urandom);
      rb  = (($urandom % 4) == 0) ? 8'($urandom % 8) : 8'($urandom);
      rci = 1'($urandom);
      x   = model(rm, int'(rc), int'(ra), int'(rb), int'(rci));
      drive_op(rm, rc, ra, rb, rci);
      check($sformatf("rand_%0d m=%0d c=%0d a=%h b=%h", i, rm, rc, ra, rb), x.res, x.fl);
      inp_valid = 2'b00;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
